// File: rtl/mips_bus_pkg.sv
// Shared types for the mips_cpu_bus master: access sizes, FSM states, lane masks.
package mips_bus_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [BE_W-1:0] BE_BYTE    = 4'b0001;
  localparam logic [BE_W-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BE_W-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BE_W-1:0] BE_WORD    = 4'b1111;

  // Request fields kept for the duration of a bus access
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       sgn;
    logic [1:0] a_lo;
  } req_lat_t;

endpackage

// File: rtl/mips_cpu_bus_master_if.sv
// Core request/response and Avalon-MM signals of the mips_cpu_bus master.
interface mips_cpu_bus_master_if;
  import mips_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_error;
  logic [DATA_W-1:0] resp_rdata;

  logic [ADDR_W-1:0] address;
  logic              write;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );

endinterface

// File: rtl/mips_bus_lane_align.sv
// Little-endian lane steering: byteenable, store replication, load extract/extend, legality flags.
module mips_bus_lane_align
  import mips_bus_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        a_lo,
  input  logic              sgn,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata,
  output logic [BE_W-1:0]   be_c,
  output logic [DATA_W-1:0] wdata_c,
  output logic [DATA_W-1:0] rdata_c,
  output logic              misaligned_c,
  output logic              illegal_c
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted      = rdata >> {a_lo, 3'b000};
    be_c         = '0;
    wdata_c      = wdata;
    rdata_c      = rdata;
    misaligned_c = 1'b0;
    illegal_c    = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_c    = BE_BYTE << a_lo;
        wdata_c = {4{wdata[7:0]}};
        rdata_c = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_c         = a_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        wdata_c      = {2{wdata[15:0]}};
        rdata_c      = {{16{sgn & shifted[15]}}, shifted[15:0]};
        misaligned_c = a_lo[0];
      end
      SZ_WORD: begin
        be_c         = BE_WORD;
        misaligned_c = |a_lo;
      end
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_master.sv
// Avalon-MM master: runs one core fetch/load/store as a single word-aligned bus access.
module mips_cpu_bus_master
  import mips_bus_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_cpu_bus_master_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  state_t            state;
  req_lat_t          lat;
  logic [CNT_W-1:0]  wait_cnt;

  logic [1:0]        al_size;
  logic [1:0]        al_a_lo;
  logic              al_sgn;
  logic [BE_W-1:0]   be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] rdata_c;
  logic              misaligned_c;
  logic              illegal_c;

  // Aligner sees the incoming request while idle, the latched one during the access
  always_comb begin
    al_size = bus.req_size;
    al_a_lo = bus.req_addr[1:0];
    al_sgn  = bus.req_signed;
    if (state != IDLE) begin
      al_size = lat.size;
      al_a_lo = lat.a_lo;
      al_sgn  = lat.sgn;
    end
  end

  mips_bus_lane_align u_align (
    .size         (al_size),
    .a_lo         (al_a_lo),
    .sgn          (al_sgn),
    .wdata        (bus.req_wdata),
    .rdata        (bus.readdata),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .rdata_c      (rdata_c),
    .misaligned_c (misaligned_c),
    .illegal_c    (illegal_c)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= IDLE;
      lat            <= '0;
      wait_cnt       <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      bus.resp_rdata <= '0;
      bus.address    <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.byteenable <= '0;
      bus.writedata  <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      bus.resp_error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            if (illegal_c || misaligned_c) begin
              bus.resp_error <= 1'b1;
            end else begin
              lat            <= '{write: bus.req_write, size: bus.req_size,
                                  sgn: bus.req_signed, a_lo: bus.req_addr[1:0]};
              bus.address    <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.byteenable <= be_c;
              bus.writedata  <= wdata_c;
              bus.read       <= !bus.req_write;
              bus.write      <= bus.req_write;
              bus.req_ready  <= 1'b0;
              wait_cnt       <= '0;
              state          <= BUS;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.resp_valid <= 1'b1;
            if (!lat.write) bus.resp_rdata <= rdata_c;
            state          <= RESP;
          end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
            // Slave stalled too long: abandon the access
            bus.read       <= 1'b0;
            bus.write      <= 1'b0;
            bus.resp_error <= 1'b1;
            bus.req_ready  <= 1'b1;
            wait_cnt       <= '0;
            state          <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.read      <= 1'b0;
          bus.write     <= 1'b0;
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_bus_master.sv
// Directed table-driven bench for mips_cpu_bus_master plus stall, timeout and reset sequences.
module tb_mips_cpu_bus_master;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mips_cpu_bus_master_if b0 ();
  mips_cpu_bus_master_if b1 ();

  mips_cpu_bus_master dut0 (.clk(clk), .reset(reset), .bus(b0));
  mips_cpu_bus_master #(.MAX_WAIT(4)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t v [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wdata);
    b0.req_valid  = 1'b1;
    b0.req_write  = wr;
    b0.req_size   = sz;
    b0.req_signed = sg;
    b0.req_addr   = addr;
    b0.req_wdata  = wdata;
  endtask

  initial begin
    v[0]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 4'b1111, 32'h0, 32'hDEAD_BEEF};
    v[1]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80};
    v[2]  = '{1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1'b0, 32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080};
    v[3]  = '{1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h8001_1234, 1'b0, 32'h0000_0100, 4'b1100, 32'h0, 32'hFFFF_8001};
    v[4]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0200, 32'h0, 32'h1234_F00D, 1'b0, 32'h0000_0200, 4'b0011, 32'h0, 32'h0000_F00D};
    v[5]  = '{1'b0, 2'd0, 1'b1, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1'b0, 32'h0000_0000, 4'b0010, 32'h0, 32'h0000_007F};
    v[6]  = '{1'b1, 2'd0, 1'b0, 32'h0000_0302, 32'h1234_56AB, 32'h0, 1'b0, 32'h0000_0300, 4'b0100, 32'hABAB_ABAB, 32'h0000_007F};
    v[7]  = '{1'b1, 2'd2, 1'b0, 32'h0000_0404, 32'hCAFE_F00D, 32'h0, 1'b0, 32'h0000_0404, 4'b1111, 32'hCAFE_F00D, 32'h0000_007F};
    v[8]  = '{1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0000_007F};
    v[9]  = '{1'b0, 2'd1, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0000_007F};
    v[10] = '{1'b1, 2'd2, 1'b0, 32'h0000_0102, 32'h1, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0000_007F};
    v[11] = '{1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0000_007F};
    v[12] = '{1'b0, 2'd3, 1'b0, 32'h0000_0101, 32'h0, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0, 32'h0000_007F};
    v[13] = '{1'b0, 2'd0, 1'b1, 32'h0000_0002, 32'h0, 32'h00F0_0000, 1'b0, 32'h0000_0000, 4'b0100, 32'h0, 32'hFFFF_FFF0};

    reset = 1'b0;
    drive0(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    b0.req_valid = 1'b0;
    b0.waitrequest = 1'b0;
    b0.readdata = 32'h0;
    b1.req_valid = 1'b0;
    b1.req_write = 1'b0;
    b1.req_size = 2'd2;
    b1.req_signed = 1'b0;
    b1.req_addr = 32'h0;
    b1.req_wdata = 32'h0;
    b1.waitrequest = 1'b1;
    b1.readdata = 32'h0;
    tick();
    tick();

    chk("rst_ready", 32'(b0.req_ready), 32'd1);
    chk("rst_read", 32'(b0.read), 32'd0);
    chk("rst_write", 32'(b0.write), 32'd0);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_resp_error", 32'(b0.resp_error), 32'd0);
    chk("rst_address", b0.address, 32'h0);
    chk("rst_be", 32'(b0.byteenable), 32'h0);
    chk("rst_wdata", b0.writedata, 32'h0);
    chk("rst_rdata", b0.resp_rdata, 32'h0);
    reset = 1'b1;
    tick();

    // Single accesses with no stalls
    for (int i = 0; i < 14; i++) begin
      b0.readdata = v[i].rdata;
      b0.waitrequest = 1'b0;
      drive0(v[i].wr, v[i].sz, v[i].sg, v[i].addr, v[i].wdata);
      tick();
      b0.req_valid = 1'b0;
      if (v[i].err) begin
        chk($sformatf("v%0d_err", i), 32'(b0.resp_error), 32'd1);
        chk($sformatf("v%0d_nostrobe", i), 32'(b0.read | b0.write), 32'd0);
        chk($sformatf("v%0d_ready", i), 32'(b0.req_ready), 32'd1);
        tick();
        chk($sformatf("v%0d_err_pulse", i), 32'(b0.resp_error), 32'd0);
        chk($sformatf("v%0d_noresp", i), 32'(b0.resp_valid | b0.read | b0.write), 32'd0);
        chk($sformatf("v%0d_rdata_kept", i), b0.resp_rdata, v[i].e_rdata);
      end else begin
        chk($sformatf("v%0d_read", i), 32'(b0.read), 32'(!v[i].wr));
        chk($sformatf("v%0d_write", i), 32'(b0.write), 32'(v[i].wr));
        chk($sformatf("v%0d_addr", i), b0.address, v[i].e_addr);
        chk($sformatf("v%0d_be", i), 32'(b0.byteenable), 32'(v[i].e_be));
        if (v[i].wr) chk($sformatf("v%0d_wdata", i), b0.writedata, v[i].e_wdata);
        chk($sformatf("v%0d_busy", i), 32'(b0.req_ready | b0.resp_valid), 32'd0);
        tick();
        chk($sformatf("v%0d_strobe_off", i), 32'(b0.read | b0.write), 32'd0);
        chk($sformatf("v%0d_resp_valid", i), 32'(b0.resp_valid), 32'd1);
        chk($sformatf("v%0d_resp_error", i), 32'(b0.resp_error), 32'd0);
        chk($sformatf("v%0d_rdata", i), b0.resp_rdata, v[i].e_rdata);
        tick();
        chk($sformatf("v%0d_resp_pulse", i), 32'(b0.resp_valid), 32'd0);
        chk($sformatf("v%0d_ready_again", i), 32'(b0.req_ready), 32'd1);
      end
    end

    // Stalled half store: write held through five waitrequest cycles
    b0.waitrequest = 1'b1;
    drive0(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
    tick();
    b0.req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("st_write_%0d", k), 32'(b0.write), 32'd1);
      chk($sformatf("st_addr_%0d", k), b0.address, 32'h0000_0200);
      chk($sformatf("st_be_%0d", k), 32'(b0.byteenable), 32'hC);
      chk($sformatf("st_wdata_%0d", k), b0.writedata, 32'hABCD_ABCD);
      chk($sformatf("st_noresp_%0d", k), 32'(b0.resp_valid | b0.resp_error), 32'd0);
      if (k == 5) b0.waitrequest = 1'b0;
      tick();
    end
    chk("st_write_off", 32'(b0.write), 32'd0);
    chk("st_resp_valid", 32'(b0.resp_valid), 32'd1);
    chk("st_rdata_kept", b0.resp_rdata, 32'hFFFF_FFF0);
    tick();
    chk("st_resp_pulse", 32'(b0.resp_valid), 32'd0);
    chk("st_ready", 32'(b0.req_ready), 32'd1);

    // Timeout on the MAX_WAIT=4 instance
    b1.req_valid = 1'b1;
    b1.req_addr  = 32'h0000_0010;
    tick();
    b1.req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_read_%0d", k), 32'(b1.read), 32'd1);
      chk($sformatf("to_noerr_%0d", k), 32'(b1.resp_error), 32'd0);
      tick();
    end
    chk("to_read_off", 32'(b1.read), 32'd0);
    chk("to_error", 32'(b1.resp_error), 32'd1);
    chk("to_no_valid", 32'(b1.resp_valid), 32'd0);
    chk("to_ready", 32'(b1.req_ready), 32'd1);
    tick();
    chk("to_error_pulse", 32'(b1.resp_error), 32'd0);
    chk("to_idle_read", 32'(b1.read), 32'd0);

    // Reset in the middle of a stalled load
    b0.waitrequest = 1'b1;
    drive0(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0);
    tick();
    b0.req_valid = 1'b0;
    chk("mr_read_before", 32'(b0.read), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    chk("mr_read", 32'(b0.read), 32'd0);
    chk("mr_write", 32'(b0.write), 32'd0);
    chk("mr_ready", 32'(b0.req_ready), 32'd1);
    chk("mr_address", b0.address, 32'h0);
    chk("mr_rdata", b0.resp_rdata, 32'h0);
    reset = 1'b1;
    b0.waitrequest = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mr_quiet_%0d", k), 32'(b0.resp_valid | b0.resp_error | b0.read), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
